// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding
// and the default pipeline drain length.
package loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DRAIN_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/imem_loader.sv
// Streams host words into I-Mem while holding the CPU pipeline in reset.
// Optional LOADER_CHECKSUM_EN adds an XOR checksum output of the session's words.
module imem_loader
  import loader_pkg::*;
#(
  parameter int INSTR_WIDTH  = 32,
  parameter int NUM_ENTRIES  = 512,
  parameter int MEM_DEPTH    = $clog2(NUM_ENTRIES),
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [MEM_DEPTH:0]     len,
  input  logic                   s_valid,
  input  logic [INSTR_WIDTH-1:0] s_data,
  output logic                   s_ready,
  output logic                   imem_we,
  output logic [MEM_DEPTH-1:0]   imem_addr,
  output logic [INSTR_WIDTH-1:0] imem_wdata,
  output logic                   cpu_hold,
  output logic                   busy,
  output logic                   done,
  output logic                   err
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [INSTR_WIDTH-1:0] checksum
`endif
);

  // Handshake protocol: a word transfers on any rising edge where
  // s_valid and s_ready are both 1; s_ready depends only on the state.

  localparam int LW  = MEM_DEPTH + 1;
  localparam int DCW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;

  state_t         state;
  state_t         state_nxt;
  logic [LW-1:0]  len_q;
  logic [LW-1:0]  cnt;
  logic [DCW-1:0] drain_cnt;
  logic           len_ok;
  logic           accept_start;
  logic           hs;
  logic           last_word;
  logic           drain_last;

  assign len_ok       = (len != '0) && (len <= LW'(NUM_ENTRIES));
  assign accept_start = (state == ST_IDLE) && start && len_ok;
  assign hs           = s_valid && s_ready;
  assign last_word    = (cnt == len_q - 1'b1);
  assign drain_last   = (drain_cnt == DCW'(DRAIN_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept_start)     state_nxt = ST_LOAD;
      ST_LOAD:  if (hs && last_word)  state_nxt = ST_DRAIN;
      ST_DRAIN: if (drain_last)       state_nxt = ST_DONE;
      ST_DONE:                        state_nxt = ST_IDLE;
      default:                        state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    s_ready  = (state == ST_LOAD);
    cpu_hold = (state == ST_LOAD) || (state == ST_DRAIN);
    busy     = (state != ST_IDLE);
    done     = (state == ST_DONE);
  end

  // Write port is registered so the I-Mem sees the word one cycle after its handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q      <= '0;
      cnt        <= '0;
      drain_cnt  <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      err        <= 1'b0;
    end else begin
      imem_we <= hs;
      err     <= (state == ST_IDLE) && start && !len_ok;
      if (accept_start) begin
        len_q <= len;
        cnt   <= '0;
      end else if (hs) begin
        cnt <= cnt + 1'b1;
      end
      if (hs) begin
        imem_addr  <= cnt[MEM_DEPTH-1:0];
        imem_wdata <= s_data;
      end
      if (state == ST_DRAIN) drain_cnt <= drain_cnt + 1'b1;
      else                   drain_cnt <= '0;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             checksum <= '0;
    else if (accept_start) checksum <= '0;
    else if (hs)           checksum <= checksum ^ s_data;
  end
`endif

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter INSTR_WIDTH, default 32: instruction word width.
REQ-002 SHALL have parameter NUM_ENTRIES, default 512: I-Mem depth in words.
REQ-003 SHALL have parameter MEM_DEPTH, default log2(NUM_ENTRIES) = 9: I-Mem address width.
REQ-004 SHALL have parameter DRAIN_CYCLES, default 4: pipeline flush cycles after the last write.
REQ-005 SHALL have port clk  input  1: single clock, all logic on posedge.
REQ-006 SHALL have port reset  input  1: reset, asynchronous, active-high.
REQ-007 SHALL have port start  input  1: request to begin a load session, sampled in IDLE only.
REQ-008 SHALL have port len  input  MEM_DEPTH+1: word count for the session, sampled with start.
REQ-009 SHALL have port s_valid  input  1: host word valid.
REQ-010 SHALL have port s_data  input  INSTR_WIDTH: host instruction word.
REQ-011 SHALL have port s_ready  output  1: loader accepts a word.
REQ-012 SHALL have port imem_we  output  1: I-Mem write strobe.
REQ-013 SHALL have port imem_addr  output  MEM_DEPTH: I-Mem write address.
REQ-014 SHALL have port imem_wdata  output  INSTR_WIDTH: I-Mem write data.
REQ-015 SHALL have port cpu_hold  output  1: holds the pipeline datapath in reset while loading.
REQ-016 SHALL have port busy  output  1: high in any state other than IDLE.
REQ-017 SHALL have port done  output  1: one-cycle pulse when a session completes.
REQ-018 SHALL have port err  output  1: one-cycle pulse when start is rejected.

Function
REQ-019 SHALL implement states IDLE, LOAD, DRAIN, DONE.
REQ-020 IDLE: start=1 with 1<=len<=NUM_ENTRIES SHALL go to LOAD, latch len, clear word counter; next cycle cpu_hold=1.
REQ-021 IDLE: start=1 with len=0 or len>NUM_ENTRIES SHALL pulse err the next cycle and stay IDLE.
REQ-022 start SHALL be ignored outside IDLE.
REQ-023 s_ready SHALL be 1 only in LOAD; handshake occurs on a cycle with s_valid=1 and s_ready=1.
REQ-024 On each handshake the cycle after SHALL show imem_we=1, imem_addr=counter, imem_wdata=s_data; counter then increments by 1.
REQ-025 imem_we SHALL be 0 on every cycle not following a handshake; s_valid gaps SHALL stall without writes.
REQ-026 Handshake on word len-1 SHALL move LOAD to DRAIN; s_ready SHALL drop the cycle after that handshake.
REQ-027 Addresses SHALL run 0..len-1 with no wrap; len=NUM_ENTRIES ends at address NUM_ENTRIES-1.
REQ-028 DRAIN SHALL last exactly DRAIN_CYCLES cycles with cpu_hold=1, then go to DONE.
REQ-029 DONE SHALL last one cycle: done=1, cpu_hold=0, next state IDLE.
REQ-030 cpu_hold SHALL be 1 in LOAD and DRAIN only.

Reset
REQ-031 reset=1 SHALL asynchronously force IDLE, counter 0, and all outputs 0, including mid-session.
REQ-032 A session interrupted by reset SHALL not resume; the host restarts with start.

Configuration
REQ-033 With LOADER_CHECKSUM_EN defined, SHALL add output checksum (INSTR_WIDTH): XOR of all words accepted this session, cleared on session start and reset, stable from DONE until the next start.
REQ-034 Without LOADER_CHECKSUM_EN, SHALL have no checksum port or logic.

Structure
REQ-035 SHALL place state encoding and the DRAIN_CYCLES default in shared package loader_pkg.
REQ-036 SHALL be a single module; no sub-module required.

Verification
REQ-037 len=3, words 0xA1,0xB2,0xC3 back-to-back -> writes addr 0,1,2 with matching data; cpu_hold high 3+4 cycles after start; done pulse; checksum 0xD0.
REQ-038 len=2, s_valid low for 5 cycles between words -> exactly 2 imem_we pulses, addr 0 then 1.
REQ-039 start with len=0, then len=513 -> err pulse each time, busy stays 0, no writes.
REQ-040 len=512 stream -> last write addr 511, no wrap, done after 4 drain cycles.
REQ-041 Reset asserted after 2 of 5 words -> immediate IDLE, all outputs 0; new start len=1 writes addr 0.
REQ-042 start pulsed during LOAD with len=7 -> ignored, original len completes.
